// File: rtl/banco_memoria_param.sv
// rtl/banco_memoria_param.sv - byte-addressed data memory with sub-word access and clear sweep
//
// Purpose: word-organised data memory between the ALU address path and the write-back mux.
//   Byte/half/word loads and stores with sign or zero extension, a registered load result
//   with a valid pulse, an alignment-error pulse, and a zeroing sweep after every reset.
// Ports:
//   clock, reset_n           rising-edge clock, asynchronous active-low reset
//   EscreveMemoria/LeMemoria store / load request, sampled at the rising edge
//   Tamanho, SemSinal        access size (00 byte, 01 half, 10 word, 11 reserved), zero-extend
//   Endereco, DadoSalvo      byte address, store data (sub-word stores use the low bits)
//   DadoCarregado/DadoValido registered load result and its one-cycle valid pulse
//   Ocupado                  high while the clear sweep runs; requests are ignored
//   ErroAlinhamento          one-cycle pulse after a misaligned or reserved-size request
module banco_memoria_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int MODO_LEITURA = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  EscreveMemoria,
    input  logic                  LeMemoria,
    input  logic [1:0]            Tamanho,
    input  logic                  SemSinal,
    input  logic [ADDR_WIDTH-1:0] Endereco,
    input  logic [DATA_WIDTH-1:0] DadoSalvo,
    output logic [DATA_WIDTH-1:0] DadoCarregado,
    output logic                  DadoValido,
    output logic                  Ocupado,
    output logic                  ErroAlinhamento
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int DEPTH = (2 ** ADDR_WIDTH) / NB;
    localparam int IDX_W = ADDR_WIDTH - OFF_W;
    localparam int SH_W  = $clog2(DATA_WIDTH);

    typedef enum logic {LIMPA, PRONTO} estado_t;

    estado_t               r_estado;
    estado_t               w_prox;
    logic [IDX_W-1:0]      r_cont;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dado;
    logic                  r_valido;
    logic                  r_erro;

    logic [IDX_W-1:0]      w_idx;
    logic [OFF_W-1:0]      w_off;
    logic [SH_W-1:0]       w_sh;
    logic                  w_desal;
    logic [NB-1:0]         w_lanes;
    logic                  w_pronto;
    logic                  w_store;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_dado_sh;
    logic [DATA_WIDTH-1:0] w_palavra;
    logic [DATA_WIDTH-1:0] w_mesclada;
    logic [DATA_WIDTH-1:0] w_fonte;
    logic [DATA_WIDTH-1:0] w_alinhado;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_idx     = Endereco[ADDR_WIDTH-1:OFF_W];
    assign w_off     = Endereco[OFF_W-1:0];
    assign w_sh      = {w_off, 3'b000};
    assign w_pronto  = (r_estado == PRONTO);
    assign w_store   = w_pronto && !w_desal && EscreveMemoria;
    assign w_load    = w_pronto && !w_desal && LeMemoria;
    assign w_dado_sh = DadoSalvo << w_sh;
    assign w_palavra = r_mem[w_idx];

    always_comb begin
        w_desal = 1'b1;
        w_lanes = '1;
        case (Tamanho)
            2'b00: begin
                w_desal = 1'b0;
                w_lanes = NB'(1) << w_off;
            end
            2'b01: begin
                w_desal = Endereco[0];
                w_lanes = NB'(3) << w_off;
            end
            2'b10: begin
                w_desal = |w_off;
                w_lanes = '1;
            end
            default: begin
                w_desal = 1'b1;
                w_lanes = '1;
            end
        endcase
    end

    // Word as it will look after this edge's store; only used in write-first mode.
    always_comb begin
        w_mesclada = w_palavra;
        for (int l = 0; l < NB; l++) begin
            if (w_lanes[l]) begin
                w_mesclada[l*8 +: 8] = w_dado_sh[l*8 +: 8];
            end
        end
    end

    // Load and store share one address, so a same-edge store always hits the loaded word.
    assign w_fonte    = (MODO_LEITURA != 0 && w_store) ? w_mesclada : w_palavra;
    assign w_alinhado = w_fonte >> w_sh;

    always_comb begin
        w_ext = w_alinhado;
        if (Tamanho == 2'b00) begin
            for (int i = 8; i < DATA_WIDTH; i++) begin
                w_ext[i] = ~SemSinal & w_alinhado[7];
            end
        end else if (Tamanho == 2'b01) begin
            for (int i = 16; i < DATA_WIDTH; i++) begin
                w_ext[i] = ~SemSinal & w_alinhado[15];
            end
        end
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            LIMPA:   if (r_cont == IDX_W'(DEPTH - 1)) w_prox = PRONTO;
            PRONTO:  w_prox = PRONTO;
            default: w_prox = LIMPA;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= LIMPA;
            r_cont   <= '0;
        end else begin
            r_estado <= w_prox;
            if (r_estado == LIMPA) begin
                r_cont <= r_cont + 1'b1;
            end
        end
    end

    // Storage has no reset of its own: the sweep zeroes it word by word.
    always_ff @(posedge clock) begin
        if (r_estado == LIMPA) begin
            r_mem[r_cont] <= '0;
        end else if (w_store) begin
            for (int l = 0; l < NB; l++) begin
                if (w_lanes[l]) begin
                    r_mem[w_idx][l*8 +: 8] <= w_dado_sh[l*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dado   <= '0;
            r_valido <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            r_valido <= w_load;
            r_erro   <= w_pronto && w_desal && (EscreveMemoria || LeMemoria);
            if (w_load) begin
                r_dado <= w_ext;
            end
        end
    end

    assign DadoCarregado   = r_dado;
    assign DadoValido      = r_valido;
    assign ErroAlinhamento = r_erro;
    assign Ocupado         = (r_estado == LIMPA);
endmodule

// File: tb/tb_banco_memoria_param.sv
// tb/tb_banco_memoria_param.sv - self-checking bench for banco_memoria_param
module tb_banco_memoria_param;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        EscreveMemoria, LeMemoria, SemSinal;
    logic [1:0]  Tamanho;
    logic [7:0]  Endereco;
    logic [31:0] DadoSalvo;
    logic [31:0] d0, d1;
    logic        v0, v1, o0, o1, e0, e1;

    banco_memoria_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MODO_LEITURA(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .EscreveMemoria(EscreveMemoria), .LeMemoria(LeMemoria),
        .Tamanho(Tamanho), .SemSinal(SemSinal), .Endereco(Endereco), .DadoSalvo(DadoSalvo),
        .DadoCarregado(d0), .DadoValido(v0), .Ocupado(o0), .ErroAlinhamento(e0));

    banco_memoria_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MODO_LEITURA(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .EscreveMemoria(EscreveMemoria), .LeMemoria(LeMemoria),
        .Tamanho(Tamanho), .SemSinal(SemSinal), .Endereco(Endereco), .DadoSalvo(DadoSalvo),
        .DadoCarregado(d1), .DadoValido(v1), .Ocupado(o1), .ErroAlinhamento(e1));

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: flat byte array, little-endian words.
    logic [7:0]  mb [256];
    logic [31:0] exp_d0, exp_d1;
    logic        exp_v, exp_e;

    typedef struct {
        logic        we, re;
        logic [1:0]  sz;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] e0, e1;
        logic        ev, ee;
    } vec_t;
    vec_t tab [15];

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic desal(input logic [1:0] sz, input logic [7:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ler(input logic [1:0] sz, input logic sgn, input logic [7:0] a);
        int nb = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[int'(a) + i];
        if (nb < 4 && !sgn && v[8*nb-1]) begin
            for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mb[i] = 8'h00;
        exp_d0 = '0; exp_d1 = '0; exp_v = 1'b0; exp_e = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic re, input logic [1:0] sz, input logic sgn,
                              input logic [7:0] a, input logic [31:0] d);
        if ((we || re) && desal(sz, a)) begin
            exp_e = 1'b1;
            exp_v = 1'b0;
        end else begin
            exp_e = 1'b0;
            exp_v = re;
            if (re) exp_d0 = ler(sz, sgn, a);
            if (we) begin
                for (int i = 0; i < (1 << sz); i++) mb[int'(a) + i] = d[8*i +: 8];
            end
            if (re) exp_d1 = ler(sz, sgn, a);
        end
    endtask

    task automatic apply(input logic we, input logic re, input logic [1:0] sz, input logic sgn,
                         input logic [7:0] a, input logic [31:0] d);
        EscreveMemoria = we; LeMemoria = re; Tamanho = sz; SemSinal = sgn;
        Endereco = a; DadoSalvo = d;
        model_step(we, re, sz, sgn, a, d);
        step();
        EscreveMemoria = 1'b0; LeMemoria = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " data0"}, d0, exp_d0);
        chk({tag, " data1"}, d1, exp_d1);
        chk({tag, " valid"}, {31'd0, v0, v1} , {30'd0, exp_v, exp_v});
        chk({tag, " err"},   {30'd0, e0, e1}, {30'd0, exp_e, exp_e});
    endtask

    int n;

    initial begin
        tab[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 8'h3C, 32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b0};
        tab[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 8'h1C, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
        tab[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 8'h1C, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
        tab[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'h1D, 32'h00000080, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tab[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'h1D, 32'h0,        32'hFFFFFF80, 32'hFFFFFF80, 1'b1, 1'b0};
        tab[5]  = '{1'b0, 1'b1, 2'd0, 1'b1, 8'h1D, 32'h0,        32'h00000080, 32'h00000080, 1'b1, 1'b0};
        tab[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 8'h1C, 32'h0,        32'hDEAD80EF, 32'hDEAD80EF, 1'b1, 1'b0};
        tab[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h1F, 32'h0,        32'hDEAD80EF, 32'hDEAD80EF, 1'b0, 1'b1};
        tab[8]  = '{1'b1, 1'b0, 2'd2, 1'b0, 8'h1E, 32'h12345678, 32'hDEAD80EF, 32'hDEAD80EF, 1'b0, 1'b1};
        tab[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 8'h1C, 32'h0,        32'hDEAD80EF, 32'hDEAD80EF, 1'b1, 1'b0};
        tab[10] = '{1'b0, 1'b1, 2'd3, 1'b0, 8'h00, 32'h0,        32'hDEAD80EF, 32'hDEAD80EF, 1'b0, 1'b1};
        tab[11] = '{1'b1, 1'b1, 2'd2, 1'b0, 8'h20, 32'h11111111, 32'h00000000, 32'h11111111, 1'b1, 1'b0};
        tab[12] = '{1'b0, 1'b1, 2'd1, 1'b0, 8'h1E, 32'h0,        32'hFFFFDEAD, 32'hFFFFDEAD, 1'b1, 1'b0};
        tab[13] = '{1'b1, 1'b1, 2'd1, 1'b1, 8'h22, 32'h0000ABCD, 32'h00001111, 32'h0000ABCD, 1'b1, 1'b0};
        tab[14] = '{1'b0, 1'b1, 2'd2, 1'b0, 8'h20, 32'h0,        32'hABCD1111, 32'hABCD1111, 1'b1, 1'b0};

        reset_n = 1'b0; EscreveMemoria = 1'b0; LeMemoria = 1'b0; Tamanho = 2'd0;
        SemSinal = 1'b0; Endereco = '0; DadoSalvo = '0;
        model_clear();
        step();
        chk("reset ocupado", {30'd0, o0, o1}, 32'd3);
        chk("reset data", d0 | d1, 32'd0);
        chk("reset valid/err", {28'd0, v0, v1, e0, e1}, 32'd0);
        step();
        reset_n = 1'b1;

        n = 0;
        while (o0 && n < 200) begin
            step();
            n++;
        end
        chk("sweep cycles", n, 64);
        chk("sweep ocupado1", {31'd0, o1}, 32'd0);

        // Directed vectors; rows 4..6 are back-to-back loads.
        for (int i = 0; i < 15; i++) begin
            apply(tab[i].we, tab[i].re, tab[i].sz, tab[i].sgn, tab[i].addr, tab[i].data);
            chk($sformatf("vec%0d data0", i), d0, tab[i].e0);
            chk($sformatf("vec%0d data1", i), d1, tab[i].e1);
            chk($sformatf("vec%0d valid", i), {30'd0, v0, v1}, {30'd0, tab[i].ev, tab[i].ev});
            chk($sformatf("vec%0d err", i),   {30'd0, e0, e1}, {30'd0, tab[i].ee, tab[i].ee});
        end

        // Randomised traffic against the byte-array model.
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  8'($urandom_range(8'h40, 8'h5F)), $urandom);
            check_model($sformatf("rnd%0d", i));
        end
        apply(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0);
        check_model("idle hold");

        // Reset pulsed mid-sweep restarts it; a store during the sweep is dropped.
        reset_n = 1'b0;
        #1;
        model_clear();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("midsweep ocupado", {31'd0, o0}, 32'd1);
        reset_n = 1'b0;
        #2;
        chk("pulse data", d0 | d1, 32'd0);
        reset_n = 1'b1;
        EscreveMemoria = 1'b1; LeMemoria = 1'b1; Tamanho = 2'd2; Endereco = 8'h00;
        DadoSalvo = 32'hCAFEF00D;
        n = 0;
        while (o0 && n < 200) begin
            step();
            n++;
            if (n == 1) begin
                EscreveMemoria = 1'b0; LeMemoria = 1'b0;
                chk("busy req ignored", {28'd0, v0, v1, e0, e1}, 32'd0);
            end
        end
        chk("resweep cycles", n, 64);
        apply(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 32'h0);
        chk("busy store dropped", d0, 32'h0);
        check_model("post resweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
